// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Hazard-detect inputs and pipeline-control outputs shared by the
//               IF/ID, ID/EX stages and the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              idex_mem_read;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] ifid_rs;
    logic [REG_AW-1:0] ifid_rt;
    logic              ifid_uses_rt;
    logic              dmem_busy;
    logic              branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_zero;
    logic              stall_active;

    modport master (
        output idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               dmem_busy, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_zero, stall_active
    );

    modport slave (
        input  idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               dmem_busy, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_zero, stall_active
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Load-use stall, memory freeze and branch flush control for the
//               5-stage pipeline. Optional stall counter: HAZARD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W           = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      perf_stall_cnt
`endif
);

    localparam logic [0:0] c_st_idle     = 1'b0;
    localparam logic [0:0] c_st_lu_stall = 1'b1;
    localparam logic [2:0] c_rem_load    = 3'(LOAD_USE_STALLS - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [2:0]        r_rem;
    logic [2:0]        w_rem_nxt;
    logic [REG_AW-1:0] w_ld_rt;
    logic              w_hit;

    assign w_ld_rt = hz.idex_rt;
    assign w_hit   = hz.idex_mem_read && (w_ld_rt != {REG_AW{1'b0}}) &&
                     ((w_ld_rt == hz.ifid_rs) ||
                      (hz.ifid_uses_rt && (w_ld_rt == hz.ifid_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rem_nxt       = r_rem;
        hz.pc_write     = 1'b1;
        hz.ifid_write   = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_zero    = 1'b0;
        hz.stall_active = 1'b0;
        if (rst) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_zero  = 1'b1;
            w_state_nxt   = c_st_idle;
            w_rem_nxt     = 3'd0;
        end else if (hz.dmem_busy) begin
            // Freeze: every stage holds, including ID/EX, so state is untouched.
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.stall_active = 1'b1;
        end else if (hz.branch_taken) begin
            hz.ifid_flush = 1'b1;
            hz.idex_zero  = 1'b1;
            w_state_nxt   = c_st_idle;
            w_rem_nxt     = 3'd0;
        end else if ((r_state == c_st_lu_stall) && (r_rem != 3'd0)) begin
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_zero    = 1'b1;
            hz.stall_active = 1'b1;
            w_rem_nxt       = r_rem - 3'd1;
            if (r_rem == 3'd1) begin
                w_state_nxt = c_st_idle;
            end
        end else if ((r_state == c_st_idle) && w_hit) begin
            // First bubble is issued in the detection cycle itself.
            hz.pc_write     = 1'b0;
            hz.ifid_write   = 1'b0;
            hz.idex_zero    = 1'b1;
            hz.stall_active = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                w_state_nxt = c_st_lu_stall;
                w_rem_nxt   = c_rem_load;
            end
        end else begin
            w_state_nxt = c_st_idle;
            w_rem_nxt   = 3'd0;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!hz.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed bench with three stall depths (1, 2, 3) side by side;
//               the stall counter is exercised when HAZARD_STALL_CNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // Output vector order: {pc_write, ifid_write, ifid_flush, idex_zero, stall_active}
    localparam logic [15:0] c_normal = 16'b11000;
    localparam logic [15:0] c_stall  = 16'b00011;
    localparam logic [15:0] c_freeze = 16'b00001;
    localparam logic [15:0] c_flush  = 16'b11110;
    localparam logic [15:0] c_reset  = 16'b00010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   r_checks = 0;
    int   r_fails  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5)) if_a ();
    pipeline_hazard_ctrl_if #(.REG_AW(5)) if_b ();
    pipeline_hazard_ctrl_if #(.REG_AW(5)) if_c ();

    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(1)) dut_a (.clk(clk), .rst(rst), .hz(if_a));
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(2)) dut_b (.clk(clk), .rst(rst), .hz(if_b));
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(3)) dut_c (.clk(clk), .rst(rst), .hz(if_c));

    logic [15:0] w_obs_a, w_obs_b, w_obs_c;
    assign w_obs_a = {11'd0, if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_zero, if_a.stall_active};
    assign w_obs_b = {11'd0, if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_zero, if_b.stall_active};
    assign w_obs_c = {11'd0, if_c.pc_write, if_c.ifid_write, if_c.ifid_flush, if_c.idex_zero, if_c.stall_active};

`ifdef HAZARD_STALL_CNT_EN
    pipeline_hazard_ctrl_if #(.REG_AW(5)) if_d ();
    logic [3:0]  w_cnt_d;
    logic [15:0] w_obs_d;
    pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_USE_STALLS(1), .CNT_W(4)) dut_d (
        .clk(clk), .rst(rst), .hz(if_d), .perf_stall_cnt(w_cnt_d));
    assign w_obs_d = {11'd0, if_d.pc_write, if_d.ifid_write, if_d.ifid_flush, if_d.idex_zero, if_d.stall_active};
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        r_checks++;
        if (obs !== exp_v) begin
            r_fails++;
            $display("FAIL %s: got %05b expected %05b", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] lrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses, input logic busy, input logic br);
        if_a.idex_mem_read = mr; if_a.idex_rt = lrt; if_a.ifid_rs = rs; if_a.ifid_rt = rt;
        if_a.ifid_uses_rt = uses; if_a.dmem_busy = busy; if_a.branch_taken = br;
        if_b.idex_mem_read = mr; if_b.idex_rt = lrt; if_b.ifid_rs = rs; if_b.ifid_rt = rt;
        if_b.ifid_uses_rt = uses; if_b.dmem_busy = busy; if_b.branch_taken = br;
        if_c.idex_mem_read = mr; if_c.idex_rt = lrt; if_c.ifid_rs = rs; if_c.ifid_rt = rt;
        if_c.ifid_uses_rt = uses; if_c.dmem_busy = busy; if_c.branch_taken = br;
`ifdef HAZARD_STALL_CNT_EN
        if_d.idex_mem_read = mr; if_d.idex_rt = lrt; if_d.ifid_rs = rs; if_d.ifid_rt = rt;
        if_d.ifid_uses_rt = uses; if_d.dmem_busy = busy; if_d.branch_taken = br;
`endif
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hit_in();
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Settle, then compare all three depths (the counter DUT matches depth 1).
    task automatic expect3(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] ec);
        #2;
        check({tag, "_a"}, w_obs_a, ea);
        check({tag, "_b"}, w_obs_b, eb);
        check({tag, "_c"}, w_obs_c, ec);
`ifdef HAZARD_STALL_CNT_EN
        check({tag, "_d"}, w_obs_d, ea);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_in();
        expect3("reset", c_reset, c_reset, c_reset);
        tick();
        rst = 1'b0;
        expect3("post_reset", c_normal, c_normal, c_normal);
        tick();

        // Load-use on rs: depth 1/2/3 stalls for 1/2/3 cycles.
        hit_in();
        expect3("lu_rs_1", c_stall, c_stall, c_stall);
        tick();
        idle_in();
        expect3("lu_rs_2", c_normal, c_stall, c_stall);
        tick();
        expect3("lu_rs_3", c_normal, c_normal, c_stall);
        tick();
        expect3("lu_rs_4", c_normal, c_normal, c_normal);
        tick();

        // $0 and an unused rt never stall; a used rt does.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        expect3("reg_zero", c_normal, c_normal, c_normal);
        tick();
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0);
        expect3("rt_unused", c_normal, c_normal, c_normal);
        tick();
        drive(1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        expect3("not_load", c_normal, c_normal, c_normal);
        tick();
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
        expect3("lu_rt_1", c_stall, c_stall, c_stall);
        tick();

        // Freeze between the bubbles; frozen cycles are not counted as bubbles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
            expect3($sformatf("freeze_%0d", i), c_freeze, c_freeze, c_freeze);
            tick();
        end
        idle_in();
        expect3("after_freeze_1", c_normal, c_stall, c_stall);
        tick();
        expect3("after_freeze_2", c_normal, c_normal, c_stall);
        tick();
        expect3("after_freeze_3", c_normal, c_normal, c_normal);
        tick();

        // Branch on the second stall cycle cancels the pending bubbles.
        hit_in();
        expect3("br_stall_1", c_stall, c_stall, c_stall);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        expect3("br_flush", c_flush, c_flush, c_flush);
        tick();
        idle_in();
        expect3("br_after", c_normal, c_normal, c_normal);
        tick();

        // Asynchronous reset in the middle of a stall.
        hit_in();
        expect3("ar_stall_1", c_stall, c_stall, c_stall);
        tick();
        idle_in();
        expect3("ar_stall_2", c_normal, c_stall, c_stall);
        #1 rst = 1'b1;
        expect3("ar_async", c_reset, c_reset, c_reset);
        tick();
        rst = 1'b0;
        expect3("ar_release_1", c_normal, c_normal, c_normal);
        tick();
        expect3("ar_release_2", c_normal, c_normal, c_normal);
        tick();

`ifdef HAZARD_STALL_CNT_EN
        rst = 1'b1;
        #2;
        check("cnt_reset", 16'(w_cnt_d), 16'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("cnt_5", 16'(w_cnt_d), 16'd5);
        for (int i = 0; i < 15; i++) tick();
        check("cnt_sat", 16'(w_cnt_d), 16'd15);
        idle_in();
        tick();
        check("cnt_hold", 16'(w_cnt_d), 16'd15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
